// File: rtl/centroid_calc_if.sv
// rtl/centroid_calc_if.sv - video-in / centroid-out bundle for centroid_calc
interface centroid_calc_if;
  logic        de;
  logic        vsync;
  logic        hsync;
  logic [23:0] mask;
  logic [10:0] xcent;
  logic [9:0]  ycent;
  logic        cent_valid;
  logic        busy;

  modport master (
    output de, vsync, hsync, mask,
    input  xcent, ycent, cent_valid, busy
  );

  modport slave (
    input  de, vsync, hsync, mask,
    output xcent, ycent, cent_valid, busy
  );
endinterface

// File: rtl/centroid_calc.sv
// rtl/centroid_calc.sv - per-frame mask centroid via moment sums and two serial dividers
// Optional CENTROID_MIN_AREA_EN: require m >= MIN_AREA before publishing a centroid.
module centroid_calc #(
  parameter int IMG_W    = 1280,
  parameter int IMG_H    = 720,
  parameter int MIN_AREA = 16
) (
  input  logic            clk,
  input  logic            rst,
  centroid_calc_if.slave  vid
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        prev_vsync;
  logic        eof;
  logic        start;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic [19:0] m;
  logic [31:0] m_x, m_y;
  logic [31:0] divisor;
  logic [31:0] qx, qy, rx, ry;
  logic [4:0]  cnt;
  logic [63:0] step_x, step_y;
  logic [10:0] xq_sat;
  logic [9:0]  yq_sat;
  logic        unused_ok;

`ifdef CENTROID_MIN_AREA_EN
  localparam logic [19:0] AREA_MIN = 20'(MIN_AREA);
  assign unused_ok = ^{vid.hsync, vid.mask[23:1]};
`else
  localparam logic [19:0] AREA_MIN = 20'd1;
  assign unused_ok = ^{vid.hsync, vid.mask[23:1], 32'(MIN_AREA)};
`endif

  assign eof   = vid.vsync & ~prev_vsync;
  assign start = eof && (m >= AREA_MIN);

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] trial;
    trial = {r, q[31]} - {1'b0, d};
    if (!trial[32])
      div_step = {trial[31:0], q[30:0], 1'b1};
    else
      div_step = {r[30:0], q[31], q[30:0], 1'b0};
  endfunction

  assign step_x = div_step(rx, qx, divisor);
  assign step_y = div_step(ry, qy, divisor);
  assign xq_sat = (|qx[31:11]) ? 11'(IMG_W - 1) : qx[10:0];
  assign yq_sat = (|qy[31:10]) ? 10'(IMG_H - 1) : qy[9:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_vsync <= 1'b0;
      x_pos      <= '0;
      y_pos      <= '0;
    end else begin
      prev_vsync <= vid.vsync;
      if (vid.vsync) begin
        x_pos <= '0;
        y_pos <= '0;
      end else if (vid.de) begin
        if (x_pos == 11'(IMG_W - 1)) begin
          x_pos <= '0;
          y_pos <= (y_pos == 10'(IMG_H - 1)) ? 10'd0 : y_pos + 10'd1;
        end else begin
          x_pos <= x_pos + 11'd1;
        end
      end
    end
  end

  // eof always implies vsync high, so clearing and accumulating never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m   <= '0;
      m_x <= '0;
      m_y <= '0;
    end else if (eof) begin
      m   <= '0;
      m_x <= '0;
      m_y <= '0;
    end else if (vid.de && !vid.vsync && vid.mask[0]) begin
      m   <= m + 20'd1;
      m_x <= m_x + {21'd0, x_pos};
      m_y <= m_y + {22'd0, y_pos};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DIV;
      S_DIV:   if (cnt == 5'd31) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor        <= '0;
      qx             <= '0;
      qy             <= '0;
      rx             <= '0;
      ry             <= '0;
      cnt            <= '0;
      vid.xcent      <= '0;
      vid.ycent      <= '0;
      vid.cent_valid <= 1'b0;
      vid.busy       <= 1'b0;
    end else begin
      vid.cent_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            divisor  <= {12'd0, m};
            qx       <= m_x;
            qy       <= m_y;
            rx       <= '0;
            ry       <= '0;
            cnt      <= '0;
            vid.busy <= 1'b1;
          end
        end
        S_DIV: begin
          {rx, qx} <= step_x;
          {ry, qy} <= step_y;
          cnt      <= cnt + 5'd1;
        end
        S_DONE: begin
          vid.xcent      <= xq_sat;
          vid.ycent      <= yq_sat;
          vid.cent_valid <= 1'b1;
          vid.busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/centroid_calc.md
Name: centroid_calc

Overview:
- Computes the centroid of the binary object mask over one video frame.
- Sits directly upstream of the crosshair overlay stage and drives its xcent/ycent inputs.
- Per-frame operation:
  - Accumulates pixel count and x/y moment sums while the frame streams in.
  - At end of frame, runs two sequential dividers.
  - Publishes the new centroid with a one-cycle valid strobe.

Parameters:
- IMG_W, 1280, active pixels per line.
- IMG_H, 720, active lines per frame.
- MIN_AREA, 16, minimum object pixel count for a centroid update. Used only with CENTROID_MIN_AREA_EN.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- de  in  1  data enable, pixel valid
- vsync  in  1  vertical sync, active-high
- hsync  in  1  horizontal sync; unused internally, kept for port symmetry
- mask  in  24  binarised pixel; object pixel when mask[0]==1
- xcent  out  11  centroid x, registered
- ycent  out  10  centroid y, registered
- cent_valid  out  1  one-cycle strobe when xcent/ycent update
- busy  out  1  high while division is in progress

Behaviour:
- Reset (async assert, sync release): x_pos, y_pos, m, m_x, m_y, xcent, ycent, cent_valid, busy all 0; FSM enters IDLE.
- Position tracking:
  - While vsync is high, x_pos and y_pos are forced to 0.
  - Otherwise, on each de cycle, x_pos increments.
  - At x_pos==IMG_W-1, x_pos wraps to 0 and y_pos increments.
  - At y_pos==IMG_H-1, y_pos wraps to 0.
- Accumulation: on a cycle with de && !vsync && mask[0], apply m+=1, m_x+=x_pos, m_y+=y_pos, all using the current pre-increment position.
- Accumulator widths: m 20b, m_x 32b, m_y 32b. No overflow is possible at the default parameters.
- eof: one-cycle pulse on a vsync rising edge (prev_vsync==0 && vsync==1), with prev_vsync registered.
- On eof, in every state:
  - Accumulators clear to 0 on the next edge.
  - A pixel with de && mask[0] in the eof cycle is ignored, because vsync is high.
- FSM IDLE:
  - eof with m>=1 → latch m, m_x, m_y into the divider operand registers → DIV; busy=1.
  - eof with m==0 → stay in IDLE; xcent/ycent hold; no strobe.
- FSM DIV:
  - Two parallel restoring dividers: m_x/m and m_y/m, unsigned.
  - One quotient bit per cycle, MSB first, 32 iterations, counted by a 5-bit counter.
  - After the 32nd iteration → DONE.
- FSM DONE (1 cycle):
  - xcent <= quotient_x[10:0], ycent <= quotient_y[9:0].
  - Quotients are truncated (floor). Saturate to IMG_W-1 / IMG_H-1 if the upper bits are nonzero (defensive).
  - cent_valid=1 for this one cycle; busy=0; → IDLE.
- Latency: if eof is sampled at edge E, xcent/ycent/cent_valid update at edge E+33 and cent_valid is high for exactly one cycle.
- eof while in DIV or DONE:
  - The division in flight completes unchanged.
  - The new frame's totals are discarded; accumulators still clear.
  - No extra strobe is produced.
- Reset mid-division: aborts immediately; outputs return to 0; no strobe.
- xcent/ycent change only in DONE or on reset; they hold across empty frames.

Optional Feature:
- Macro CENTROID_MIN_AREA_EN.
- Defined: IDLE→DIV requires m>=MIN_AREA. Frames with 0<m<MIN_AREA behave like empty frames: outputs hold, no strobe.
- Undefined: threshold is m>=1; the MIN_AREA parameter is ignored.

Test Plan:
- Single object pixel at (100,50), then vsync rise → 33 edges later cent_valid=1 for 1 cycle; xcent=100, ycent=50; busy high for 33 cycles (DIV plus DONE).
- Rectangle x=10..19, y=20..29 (m=100, m_x=1450, m_y=2450) → xcent=14 (floor of 14.5), ycent=24.
- Frame with one object pixel at (100,50), then an empty frame → after the first frame's update, no strobe on the second vsync; xcent=100/ycent=50 retained.
- Frame A: centroid (100,50). Second vsync pulsed 5 cycles after A's eof, with frame B pixels in between → A's result (100,50) is published once; B's totals are discarded; accumulators are 0 after B's eof.
- rst asserted 10 cycles into DIV → outputs immediately 0, busy=0, no strobe. Next frame with pixel (7,3) → xcent=7, ycent=3.
- With CENTROID_MIN_AREA_EN, MIN_AREA=16: a 15-pixel frame gives no update; a 16-pixel 4x4 block at (0..3, 0..3) gives xcent=1, ycent=1.
